// File: rtl/mul_32_seq.sv
// mul_32_seq: sequential 32x32 signed radix-2 Booth multiplier, one step per clock,
// 64-bit product delivered as registered hi/lo words with a one-cycle done pulse.
module mul_32_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [32:0] a;
    logic [31:0] q;
    logic        q_1;
    logic [31:0] m;
    logic [5:0]  count;
    logic [32:0] m_ext;
    logic [32:0] a_sum;
    logic [32:0] a_n;
    logic [31:0] q_n;
    logic        q1_n;
    // A is one bit wider than M so that adding/subtracting -2^31 never overflows
    always_comb begin
        m_ext = {m[31], m};
        a_sum = ({q[0], q_1} == 2'b01) ? a + m_ext :
                ({q[0], q_1} == 2'b10) ? a - m_ext : a;
        {a_n, q_n, q1_n} = {a_sum[32], a_sum, q};
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    a     <= a_n;
                    q     <= q_n;
                    q_1   <= q1_n;
                    count <= count - 6'd1;
                    if (count == 6'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= a_n[31:0];
                        lo    <= q_n;
                    end
                end
                default: begin
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        q_1   <= 1'b0;
                        count <= 6'd32;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_32_seq.sv
// tb_mul_32_seq: table-driven, random and handshake/reset checks of mul_32_seq
// against a plain signed-multiply reference model.
module tb_mul_32_seq;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int n_chk = 0;
    int n_fail = 0;

    mul_32_seq dut (
        .clk(clk), .clr(clr), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is first seen high.
    task automatic mul(input string nm, input logic [31:0] mv, input logic [31:0] qv,
                       input logic [63:0] exp, input int inj);
        int lat;
        int bc;
        multiplicand = mv;
        multiplier   = qv;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~mv;
        multiplier   = qv ^ 32'h5a5a_1234;
        lat = 0;
        bc  = int'(busy);
        while (!done && lat < 100) begin
            if (lat == inj) begin
                start        = 1'b1;
                multiplicand = 32'd5;
                multiplier   = 32'd9;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (!done) bc += int'(busy);
        end
        chk({nm, "_latency"}, 64'(lat), 64'd32);
        chk({nm, "_busy_cycles"}, 64'(bc), 64'd32);
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, "_product"}, {hi, lo}, exp);
    endtask

    initial begin
        vec_t vt[6];
        logic [31:0] rm, rq, h0, l0;
        int bad;
        int seen;
        vt[0] = '{32'd7,         32'd6,         32'h0000_0000, 32'h0000_002a};
        vt[1] = '{-32'sd3,       32'd5,         32'hffff_ffff, 32'hffff_fff1};
        vt[2] = '{32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0001};
        vt[3] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vt[4] = '{32'h7fff_ffff, 32'h7fff_ffff, 32'h3fff_ffff, 32'h0000_0001};
        vt[5] = '{32'h8000_0000, 32'h7fff_ffff, 32'hc000_0000, 32'h8000_0000};

        #12;
        chk("reset_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mul($sformatf("vec%0d", i), vt[i].m, vt[i].q, {vt[i].hi, vt[i].lo}, -1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        for (int i = 0; i < 20; i++) begin
            rm = $urandom;
            rq = $urandom;
            if (i == 0) rq = 32'h0;
            mul($sformatf("rnd%0d", i), rm, rq, model(rm, rq), -1);
            @(negedge clk);
        end

        mul("ignored_start", 32'd1234567, 32'hfffe_0001, model(32'd1234567, 32'hfffe_0001), 10);
        @(negedge clk);
        chk("ignored_start_no_rerun", 64'({busy, done}), 64'd0);

        mul("b2b_first", 32'd7, 32'd6, 64'd42, -1);
        mul("b2b_second", 32'd2, 32'd3, 64'd6, -1);

        h0 = hi;
        l0 = lo;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (hi !== h0 || lo !== l0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("hold_100", 64'(bad), 64'd0);

        multiplicand = 32'h1234_5678;
        multiplier   = 32'h8765_4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 clr = 1'b0;
        #1;
        chk("async_reset_outputs", {30'd0, busy, done, hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);
        mul("after_reset", 32'd4, -32'sd4, 64'hffff_ffff_ffff_fff0, -1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
